// File: rtl/serial_sum_collector.sv
// serial_sum_collector
//   Receive end of the serial adder datapath. Captures the LSB-first sum bit
//   stream and the final carry, assembles a WIDTH-bit parallel result and
//   hands it to the consumer with a valid/ack handshake. A sticky overrun
//   flag records a result discarded by a new load before it was acknowledged.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   load       operation (re)start strobe, highest priority
//   enable     shift strobe, qualifies sum_bit / carry_bit
//   sum_bit    serial sum bit, LSB first
//   carry_bit  carry out of the current bit position
//   rd_ack     consumer accepts result while valid is high
//   ovr_clr    clears the sticky overrun flag
//   result     assembled sum, stable while valid
//   cout       carry out of bit WIDTH-1
//   valid      result/cout available
//   busy       operation armed or collecting
//   overrun    sticky: an unacknowledged result was discarded
//   bit_cnt    bits captured in the current operation

module serial_sum_collector #(
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             enable,
    input  logic             sum_bit,
    input  logic             carry_bit,
    input  logic             rd_ack,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCollect,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    // Incoming bit enters at the MSB so that after WIDTH shifts bit 0 is the first bit received.
    assign shifted  = {sum_bit, shreg[WIDTH-1:1]};
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= StIdle;
            shreg   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (ovr_clr) begin
                overrun <= 1'b0;
            end

            if (load) begin
                // A set from a discarded result overrides a simultaneous clear.
                if (state == StDone && valid && !rd_ack) begin
                    overrun <= 1'b1;
                end
                if (state == StDone) begin
                    valid <= 1'b0;
                end
                state   <= StArmed;
                busy    <= 1'b1;
                bit_cnt <= '0;
                shreg   <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        // Stray enables without a load are dropped.
                    end
                    StArmed, StCollect: begin
                        if (enable) begin
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (last_bit) begin
                                result <= shifted;
                                cout   <= carry_bit;
                                valid  <= 1'b1;
                                state  <= StDone;
                                busy   <= 1'b0;
                            end else begin
                                state <= StCollect;
                            end
                        end
                    end
                    StDone: begin
                        // The adder keeps shifting after completion; those bits are ignored.
                        if (rd_ack) begin
                            valid <= 1'b0;
                            state <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_sum_collector.sv
module tb_serial_sum_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         load = 1'b0;
    logic         enable = 1'b0;
    logic         sum_bit = 1'b0;
    logic         carry_bit = 1'b0;
    logic         rd_ack = 1'b0;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] result;
    logic         cout;
    logic         valid;
    logic         busy;
    logic         overrun;
    logic [3:0]   bit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    serial_sum_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .enable    (enable),
        .sum_bit   (sum_bit),
        .carry_bit (carry_bit),
        .rd_ack    (rd_ack),
        .ovr_clr   (ovr_clr),
        .result    (result),
        .cout      (cout),
        .valid     (valid),
        .busy      (busy),
        .overrun   (overrun),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n);
        load = 1'b1;
        repeat (n) tick();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) tick();
    endtask

    // Sends the first nbits of v LSB first. gaps[i] inserts one idle cycle before bit i.
    // early reports valid seen high before the final bit of a full stream.
    task automatic send_stream(input logic [W-1:0] v, input logic c, input logic [W-1:0] gaps,
                               input int nbits, output logic early);
        early = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (gaps[i] && i > 0) begin
                enable  = 1'b0;
                sum_bit = 1'($urandom);
                tick();
                if (valid) early = 1'b1;
            end
            enable    = 1'b1;
            sum_bit   = v[i];
            carry_bit = (i == W - 1) ? c : 1'($urandom);
            tick();
            if (i < W - 1 && valid) early = 1'b1;
        end
        enable    = 1'b0;
        carry_bit = 1'b0;
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        n_cmp++; if ({result, cout, valid, busy, overrun, bit_cnt} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h required 0",
                              {result, cout, valid, busy, overrun, bit_cnt}); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic early;
        do_load(2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_armed: got %b required 1", busy); end
        send_stream(8'hA5, 1'b1, 8'h00, W, early);
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b required 0", early); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b required 1", valid); end
        n_cmp++; if (result !== 8'hA5) begin n_err++; $display("FAIL basic_result: got %h required a5", result); end
        n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL basic_cout: got %b required 1", cout); end
        n_cmp++; if (bit_cnt !== 4'd8) begin n_err++; $display("FAIL basic_bit_cnt: got %0d required 8", bit_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_done: got %b required 0", busy); end
        idle(2);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_hold: got %b required 1", valid); end
        ack();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_after_ack: got %b required 0", valid); end
        n_cmp++; if (result !== 8'hA5) begin n_err++; $display("FAIL basic_result_after_ack: got %h required a5", result); end
    endtask

    task automatic test_gaps();
        logic early;
        do_load(1);
        // Gaps between bits 3/4 and 6/7 (1-based) land before indices 3 and 6.
        send_stream(8'hA5, 1'b0, 8'b0100_1000, W, early);
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL gaps_early_valid: got %b required 0", early); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL gaps_valid: got %b required 1", valid); end
        n_cmp++; if (result !== 8'hA5) begin n_err++; $display("FAIL gaps_result: got %h required a5", result); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL gaps_cout: got %b required 0", cout); end
        ack();
    endtask

    task automatic test_overrun();
        logic early;
        do_load(1);
        send_stream(8'h3C, 1'b0, 8'h00, W, early);
        idle(3);
        n_cmp++; if (result !== 8'h3C) begin n_err++; $display("FAIL ovr_first_result: got %h required 3c", result); end
        do_load(1);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b required 1", overrun); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_dropped: got %b required 0", valid); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovr_armed_busy: got %b required 1", busy); end
        send_stream(8'h01, 1'b1, 8'h00, W, early);
        n_cmp++; if (result !== 8'h01) begin n_err++; $display("FAIL ovr_second_result: got %h required 01", result); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b required 1", overrun); end
        // Clear and a fresh overrun on the same edge: overrun must stay set.
        ovr_clr = 1'b1;
        do_load(1);
        ovr_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_clr_vs_set: got %b required 1", overrun); end
        send_stream(8'h77, 1'b0, 8'h00, W, early);
        ack();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b required 0", overrun); end
    endtask

    task automatic test_restart();
        logic early;
        do_load(1);
        send_stream(8'($urandom), 1'b0, 8'h00, 5, early);
        n_cmp++; if (bit_cnt !== 4'd5) begin n_err++; $display("FAIL restart_partial_cnt: got %0d required 5", bit_cnt); end
        n_cmp++; if (result !== 8'h77) begin n_err++; $display("FAIL restart_partial_hidden: got %h required 77", result); end
        do_load(1);
        n_cmp++; if (bit_cnt !== 4'd0) begin n_err++; $display("FAIL restart_cnt_cleared: got %0d required 0", bit_cnt); end
        send_stream(8'hFF, 1'b1, 8'h00, W, early);
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL restart_early_valid: got %b required 0", early); end
        n_cmp++; if (result !== 8'hFF) begin n_err++; $display("FAIL restart_result: got %h required ff", result); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL restart_overrun: got %b required 0", overrun); end
        ack();
    endtask

    task automatic test_back_to_back();
        logic early;
        do_load(1);
        send_stream(8'h5A, 1'b0, 8'h00, W, early);
        for (int i = 0; i < 6; i++) begin
            enable  = 1'($urandom);
            sum_bit = 1'($urandom);
            tick();
        end
        enable = 1'b0;
        n_cmp++; if (result !== 8'h5A) begin n_err++; $display("FAIL done_result_held: got %h required 5a", result); end
        n_cmp++; if (bit_cnt !== 4'd8) begin n_err++; $display("FAIL done_cnt_held: got %0d required 8", bit_cnt); end
        rd_ack = 1'b1;
        load   = 1'b1;
        tick();
        rd_ack = 1'b0;
        load   = 1'b0;
        n_cmp++; if ({overrun, busy, valid} !== 3'b010) begin
            n_err++; $display("FAIL ack_with_load: got ovr/busy/valid=%b required 010", {overrun, busy, valid}); end
    endtask

    task automatic test_reset_mid();
        logic early;
        do_load(1);
        send_stream(8'($urandom), 1'b0, 8'h00, 4, early);
        resetn = 1'b0;
        #1;
        n_cmp++; if ({result, cout, valid, busy, overrun, bit_cnt} !== '0) begin
            n_err++; $display("FAIL midreset_outputs: got %h required 0",
                              {result, cout, valid, busy, overrun, bit_cnt}); end
        #2;
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enable  = 1'b1;
            sum_bit = 1'b1;
            tick();
        end
        enable = 1'b0;
        n_cmp++; if ({bit_cnt, valid, busy} !== '0) begin
            n_err++; $display("FAIL noload_capture: got cnt=%0d valid=%b busy=%b required 0",
                              bit_cnt, valid, busy); end
    endtask

    // Randomised operations against an arithmetic model: the expected result is the
    // transmitted word itself, and overrun is set whenever a load finds a result pending.
    task automatic test_random();
        logic [W-1:0] v;
        logic         c;
        logic         early;
        logic         pending = 1'b0;
        logic         exp_ovr = 1'b0;
        for (int op = 0; op < 30; op++) begin
            v = 8'($urandom);
            c = 1'($urandom);
            do_load($urandom_range(1, 3));
            if (pending) exp_ovr = 1'b1;
            pending = 1'b0;
            n_cmp++; if (overrun !== exp_ovr) begin n_err++; $display("FAIL rnd_overrun op %0d: got %b required %b", op, overrun, exp_ovr); end
            send_stream(v, c, 8'($urandom), W, early);
            n_cmp++; if ({early, valid} !== 2'b01) begin n_err++; $display("FAIL rnd_valid op %0d: got early/valid=%b required 01", op, {early, valid}); end
            n_cmp++; if ({cout, result} !== {c, v}) begin n_err++; $display("FAIL rnd_result op %0d: got %b/%h required %b/%h", op, cout, result, c, v); end
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                pending = 1'b1;
            end else begin
                ack();
                n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rnd_ack op %0d: got %b required 0", op, valid); end
            end
        end
        if (pending) ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_restart();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
